// File: rtl/iencode_loader.sv
// iencode_loader: packs decoded LEGv8-subset instruction fields into 32-bit
// words and writes them sequentially into instruction memory.
//
// Optional feature: define ILOAD_CHECKSUM_EN to add the csum output, which is
// the running XOR of every word written since the last start.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, base_addr       begin a program load at base_addr (word aligned)
//   in_valid/in_ready      request handshake; in_last marks final request
//   opcode, rd, rn, rm,
//   imm, shamt             decoded instruction fields
//   mem_we/mem_ready       write handshake; mem_addr/mem_wdata held until accepted
//   done                   one-cycle pulse after the last word is written
//   err, err_code          sticky error and cause (1 opcode, 2 range, 3 full)
//   words                  words written since start
//   csum                   (ILOAD_CHECKSUM_EN only) XOR of written words
//
// state   | meaning
// S_IDLE  | waiting for start
// S_LOAD  | accepting requests, one registered write slot
// S_DRAIN | last request accepted, waiting for its write to complete
// S_ERROR | request rejected; outputs hold until start
module iencode_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [31:0]       imm,
  input  logic [5:0]        shamt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-2:0] words
`ifdef ILOAD_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_ERROR} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);

  state_t            state;
  logic [31:0]       enc_word;
  logic [1:0]        enc_code;
  logic [ADDR_W-1:0] fill;
  logic              full;
  logic              accept;
  logic              wr_done;

  // True when v sign-extends from bit sh, i.e. fits in sh+1 signed bits.
  function automatic logic fits(input logic [31:0] v, input int sh);
    logic signed [31:0] t;
    t = $signed(v) >>> sh;
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  always_comb begin
    enc_word = 32'h0;
    enc_code = 2'd0;
    case (opcode)
      4'd1: begin
        enc_word = {10'h244, imm[11:0], rn, rd};
        if (imm[31:12] != 20'h0) enc_code = 2'd2;
      end
      4'd2:  enc_word = {11'h558, rm, 6'h00, rn, rd};
      4'd3: begin
        enc_word = {8'h54, imm[18:0], 5'h0B};
        if (!fits(imm, 18)) enc_code = 2'd2;
      end
      4'd4: begin
        enc_word = {6'h05, imm[25:0]};
        if (!fits(imm, 25)) enc_code = 2'd2;
      end
      4'd5: begin
        enc_word = {8'hB4, imm[18:0], rd};
        if (!fits(imm, 18)) enc_code = 2'd2;
      end
      4'd6: begin
        enc_word = {11'h7C2, imm[8:0], 2'b00, rn, rd};
        if (!fits(imm, 8)) enc_code = 2'd2;
      end
      4'd7:  enc_word = {11'h69B, 5'h00, shamt, rn, rd};
      4'd8:  enc_word = {11'h69A, 5'h00, shamt, rn, rd};
      4'd9:  enc_word = {11'h4D8, rm, 6'h1F, rn, rd};
      4'd10: begin
        enc_word = {11'h7C0, imm[8:0], 2'b00, rn, rd};
        if (!fits(imm, 8)) enc_code = 2'd2;
      end
      4'd11: enc_word = {11'h758, rm, 6'h00, rn, rd};
      default: enc_code = 2'd1;
    endcase
  end

  // Occupancy counts the word still sitting in the output register.
  assign fill     = {1'b0, words} + {{(ADDR_W-1){1'b0}}, mem_we};
  assign full     = (fill == DEPTH_V);
  assign wr_done  = mem_we && mem_ready;
  assign in_ready = (state == S_LOAD) && (!mem_we || mem_ready) && !full;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      words     <= '0;
`ifdef ILOAD_CHECKSUM_EN
      csum      <= 32'h0;
`endif
    end else begin
      done <= 1'b0;
      // A write can only be pending outside IDLE; it completes in any of
      // LOAD, DRAIN or ERROR. Later assignments below override as needed.
      if (wr_done) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(4);
        words    <= words + (ADDR_W-1)'(1);
`ifdef ILOAD_CHECKSUM_EN
        csum     <= csum ^ mem_wdata;
`endif
      end
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (enc_code != 2'd0) begin
              err      <= 1'b1;
              err_code <= enc_code;
              state    <= S_ERROR;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= enc_word;
              if (in_last) state <= S_DRAIN;
            end
          end else if (full && in_valid) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            state    <= S_ERROR;
          end
        end
        S_DRAIN: begin
          if (wr_done) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          // IDLE and ERROR restart identically; a pending write is abandoned.
          if (start) begin
            mem_we   <= 1'b0;
            mem_addr <= base_addr & ~ADDR_W'(3);
            words    <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
`ifdef ILOAD_CHECKSUM_EN
            csum     <= 32'h0;
`endif
            state    <= S_LOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iencode_loader.sv
module tb_iencode_loader;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, in_last, mem_we, mem_ready, done, err;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [3:0]  opcode;
  logic [4:0]  rd, rn, rm;
  logic [31:0] imm, mem_wdata;
  logic [5:0]  shamt;
  logic [1:0]  err_code;
  logic [ADDR_W-2:0] words;
`ifdef ILOAD_CHECKSUM_EN
  logic [31:0] csum;
`endif

  iencode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .shamt(shamt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .done(done), .err(err), .err_code(err_code),
    .words(words)
`ifdef ILOAD_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  int total = 0;
  int bad   = 0;
  wr_t exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  int m_words, exp_err;
  logic [31:0] m_csum;
  int ready_mode = 1;
  int stall_pct  = 0;
  int cyc = 0, last_hs = -10, first_hs = -1, hs_count = 0;
  bit done_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit imm_range(input int op, output longint lo, output longint hi);
    lo = 0; hi = 0;
    case (op)
      1:     begin lo = 0;         hi = 4095;     return 1; end
      3, 5:  begin lo = -262144;   hi = 262143;   return 1; end
      4:     begin lo = -33554432; hi = 33554431; return 1; end
      6, 10: begin lo = -256;      hi = 255;      return 1; end
      default: return 0;
    endcase
  endfunction

  function automatic int ref_code(input int op, input logic [31:0] iv);
    longint lo, hi, v;
    v = longint'($signed(iv));
    if (op < 1 || op > 11) return 1;
    if (imm_range(op, lo, hi) && (v < lo || v > hi)) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(input int op, input logic [31:0] d,
      input logic [31:0] n, input logic [31:0] m, input logic [31:0] iv,
      input logic [31:0] s);
    logic [31:0] rr;
    rr = (n << 5) | d;
    case (op)
      1:  return (32'h244 << 22) | ((iv & 32'hFFF) << 10) | rr;
      2:  return (32'h558 << 21) | (m << 16) | rr;
      3:  return (32'h54 << 24) | ((iv & 32'h7FFFF) << 5) | 32'hB;
      4:  return (32'h5 << 26) | (iv & 32'h3FFFFFF);
      5:  return (32'hB4 << 24) | ((iv & 32'h7FFFF) << 5) | d;
      6:  return (32'h7C2 << 21) | ((iv & 32'h1FF) << 12) | rr;
      7:  return (32'h69B << 21) | (s << 10) | rr;
      8:  return (32'h69A << 21) | (s << 10) | rr;
      9:  return (32'h4D8 << 21) | (m << 16) | (32'h1F << 10) | rr;
      10: return (32'h7C0 << 21) | ((iv & 32'h1FF) << 12) | rr;
      11: return (32'h758 << 21) | (m << 16) | rr;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- memory-ready driver ----------------
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0: mem_ready = ($urandom_range(0, 99) >= stall_pct);
        1: mem_ready = 1'b1;
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    wr_t e;
    bit prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] prev_data;
    prev_stall = 0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("stall_we", mem_we, 1);
          check("stall_addr", mem_addr, prev_addr);
          check("stall_data", mem_wdata, prev_data);
        end
        if (mem_we && !mem_ready) check("stall_in_ready", in_ready, 0);
        if (mem_we && mem_ready) begin
          if (exp_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.a);
            check("wr_data", mem_wdata, e.d);
          end
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          hs_count++;
        end
        if (done) begin
          check("done_after_write", cyc, last_hs + 1);
          done_seen = 1;
        end
        prev_stall = mem_we && !mem_ready;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    for (int k = 0; k < 200 && mem_we; k++) tick();
    check("start_no_pending", mem_we, 0);
    check("start_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
    m_addr = base & ~ADDR_W'(3);
    m_words = 0; exp_err = 0; m_csum = 32'h0;
    done_seen = 0; first_hs = -1; hs_count = 0;
  endtask

  task automatic send(input int op, input int d, input int n, input int m,
                      input logic [31:0] iv, input int s, input bit last);
    int c;
    logic [31:0] w;
    opcode = op[3:0]; rd = d[4:0]; rn = n[4:0]; rm = m[4:0];
    imm = iv; shamt = s[5:0]; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        check("room_on_accept", m_words < DEPTH, 1);
        c = ref_code(op, iv);
        if (c == 0) begin
          w = ref_word(op, d, n, m, iv, s);
          exp_q.push_back({m_addr, w});
          m_addr = m_addr + ADDR_W'(4);
          m_words++;
          m_csum ^= w;
        end else exp_err = c;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      if (err) begin
        exp_err = (m_words >= DEPTH) ? 3 : 99;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_done();
    for (int k = 0; k < 300 && !done_seen; k++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done_seen, 1);
    @(negedge clk); #1;
    check("done_pulse_width", done, 0);
    check("words_end", words, m_words);
    check("err_clear", err, 0);
    check("queue_drained", exp_q.size(), 0);
`ifdef ILOAD_CHECKSUM_EN
    check("csum", csum, m_csum);
`endif
    tick();
  endtask

  task automatic finish_err();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = err && !mem_we;
    end
    check("err_flag", err, 1);
    check("err_code", err_code, exp_err);
    check("words_err", words, m_words);
    check("err_queue_drained", exp_q.size(), 0);
    tick();
  endtask

  task automatic gen(input bit allow_bad, output int op, output logic [31:0] iv);
    longint lo, hi;
    int sel;
    if (allow_bad && $urandom_range(0, 9) == 0) begin
      sel = $urandom_range(0, 4);
      op = (sel == 0) ? 0 : 11 + sel;
    end else op = $urandom_range(1, 11);
    iv = $urandom;
    if (imm_range(op, lo, hi)) begin
      sel = $urandom_range(0, 15);
      if (sel == 0 && allow_bad)      iv = 32'(lo - 1);
      else if (sel == 1 && allow_bad) iv = 32'(hi + 1);
      else if (sel == 2)              iv = 32'(lo);
      else if (sel == 3)              iv = 32'(hi);
      else iv = 32'(lo + longint'($urandom) % (hi - lo + 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op, n;
    logic [31:0] iv;
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; rd = '0; rn = '0; rm = '0; imm = '0; shamt = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_words", words, 0);
    tick();
    reset = 1'b0;

    // single ADDI with last
    ready_mode = 1;
    do_start(12'h100);
    send(1, 1, 2, 0, 32'd5, 0, 1'b1);
    finish_done();

    // back-to-back stream, no bubbles
    do_start(12'h200);
    send(4, 0, 0, 0, 32'hFFFF_FFFF, 0, 1'b0);
    send(3, 9, 0, 0, 32'd2, 0, 1'b0);
    send(9, 3, 4, 5, 32'h0, 0, 1'b0);
    send(6, 0, 1, 0, 32'hFFFF_FFF8, 0, 1'b1);
    finish_done();
    check("no_bubble_span", last_hs - first_hs, 3);
    check("stream_count", hs_count, 4);

    // memory stall of three cycles mid-stream
    do_start(12'h300);
    send(2, 1, 2, 3, 32'h0, 0, 1'b0);
    send(11, 4, 5, 6, 32'h0, 0, 1'b0);
    ready_mode = 2;
    fork
      send(7, 7, 8, 0, 32'h0, 63, 1'b0);
      begin repeat (3) tick(); ready_mode = 1; end
    join
    send(8, 10, 11, 0, 32'h0, 1, 1'b1);
    finish_done();
    check("stall_count", hs_count, 4);

    // immediate out of range, then restart clears the error
    do_start(12'h400);
    send(1, 1, 1, 0, 32'd4096, 0, 1'b1);
    finish_err();
    do_start(12'h404);
    check("restart_err", err, 0);
    check("restart_code", err_code, 0);
    check("restart_words", words, 0);
    send(1, 2, 3, 0, 32'd4095, 0, 1'b1);
    finish_done();

    // fill to DEPTH with random stalls across the address wrap, then overflow
    ready_mode = 0; stall_pct = 30;
    do_start(12'hFFA);
    for (int i = 0; i <= DEPTH; i++) begin
      gen(1'b0, op, iv);
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           iv, $urandom_range(0, 63), 1'b0);
      if (err) break;
    end
    finish_err();

    // bad opcode
    do_start(12'h010);
    send(13, 1, 1, 1, 32'h0, 0, 1'b1);
    finish_err();

    // reset while a write is pending
    ready_mode = 1;
    do_start(12'h500);
    ready_mode = 2;
    send(2, 1, 2, 3, 32'h0, 0, 1'b0);
    @(negedge clk);
    check("pre_reset_we", mem_we, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_words", words, 0);
    reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;

    // randomized programs
    for (int p = 0; p < 25; p++) begin
      stall_pct = $urandom_range(0, 60);
      do_start(ADDR_W'($urandom));
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        gen(1'b1, op, iv);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             iv, $urandom_range(0, 63), i == n - 1);
        if (exp_err != 0) break;
      end
      if (exp_err != 0) finish_err();
      else finish_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iencode_loader.md
Name: iencode_loader

Overview:
- Inverse of the core's instruction decoder: accepts decoded instruction fields (opcode, registers, immediate, shift amount) as a stream and packs each into its 32-bit LEGv8-subset word.
- Writes the packed words sequentially into instruction memory through a write port.
- Used by testbenches and the boot/program-load path to build instruction-memory images without hand-assembled hex.
- Flags unencodable requests.

Parameters:
- ADDR_W, 12, byte-address width of the instruction-memory write port.
- DEPTH, 1024, capacity in 32-bit words; must satisfy DEPTH*4 <= 2**ADDR_W.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new program load at base_addr.
- base_addr  input  ADDR_W  byte address of the first word; bits [1:0] ignored (forced 0).
- in_valid  input  1  instruction request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_last  input  1  marks the final request of the program.
- opcode  input  4  1=ADDI 2=ADDS 3=BLT 4=B 5=CBZ 6=LDUR 7=LSL 8=LSR 9=MUL 10=STUR 11=SUBS.
- rd, rn, rm  input  5 each  register fields; rd is Rt for CBZ/LDUR/STUR.
- imm  input  32  signed two's-complement immediate/offset.
- shamt  input  6  shift amount for LSL/LSR.
- mem_we  output  1  write strobe; held until mem_ready.
- mem_addr  output  ADDR_W  byte address of the word being written.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
- done  output  1  one-cycle pulse after the last word is written.
- err  output  1  sticky error flag.
- err_code  output  2  0=none, 1=bad opcode, 2=immediate/shamt out of range, 3=memory full.
- words  output  ADDR_W-1  words written since start.

Behaviour:
- States: IDLE, LOAD, DRAIN, ERROR.
- Reset: state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, err_code=0, words=0.
- IDLE:
  - in_ready=0.
  - start: mem_addr=base_addr with bits [1:0]=0, words=0, err and err_code cleared, go to LOAD.
- LOAD:
  - One output register. in_ready = !mem_we || mem_ready, plus the full rule below.
  - On accept, the next cycle has mem_we=1 with the encoded word: one-cycle latency.
  - A completed write (mem_we && mem_ready) increments mem_addr by 4 (wraps modulo 2**ADDR_W) and words by 1.
  - Write and accept in the same cycle are legal: full throughput, one word per cycle.
- Encoding, with unused bits 0:
  - B: [31:26]=6'h05, [25:0]=imm[25:0].
  - CBZ: [31:24]=8'hB4, [23:5]=imm[18:0], [4:0]=rd.
  - BLT: [31:24]=8'h54, [23:5]=imm[18:0], [4:0]=5'h0B (rd ignored).
  - ADDI: [31:22]=10'h244, [21:10]=imm[11:0], [9:5]=rn, [4:0]=rd.
  - LSR 11'h69A, LSL 11'h69B: [31:21]=opcode, [20:16]=0, [15:10]=shamt, rn, rd.
  - ADDS 11'h558, SUBS 11'h758: [20:16]=rm, [15:10]=0, rn, rd.
  - MUL: 11'h4D8, rm, [15:10]=6'h1F, rn, rd.
  - LDUR 11'h7C2, STUR 11'h7C0: [20:12]=imm[8:0], [11:10]=0, rn, rd.
- Range checks at accept:
  - ADDI: 0..4095.
  - B: -2^25..2^25-1.
  - CBZ/BLT: -2^18..2^18-1.
  - LDUR/STUR: -256..255.
  - shamt is 6 bits and always legal; imm is ignored for register-only ops.
- Error:
  - Opcode 0 or 12-15 gives err_code=1; an out-of-range imm gives err_code=2.
  - The offending request is consumed and not written.
  - err=1, go to ERROR. A pending earlier write still completes.
- Full:
  - When words + (mem_we?1:0) == DEPTH, in_ready=0.
  - If in_valid is asserted then, err_code=3, err=1, go to ERROR.
- Last: on accepting an in_last request, go to DRAIN with in_ready=0. When that write completes, done=1 for one cycle, then IDLE.
- ERROR: in_ready=0, outputs hold. start restarts exactly as from IDLE.
- start outside IDLE/ERROR is ignored.
- reset mid-load: the in-flight write is dropped, and all outputs take their reset values on the next edge.

Optional Feature:
- Macro ILOAD_CHECKSUM_EN.
- When defined: adds output port csum (32), reset/start value 0, updated to csum ^ mem_wdata on every completed write; final value valid when done pulses.
- When undefined: no port and no logic.

Test Plan:
- start base_addr=0x100, then ADDI rd=1 rn=2 imm=5 with last -> one cycle later mem_we=1, mem_addr=0x100, mem_wdata=0x91001441; done pulses the cycle after the write; words=1.
- Stream B imm=-1, BLT imm=2, MUL rd=3 rn=4 rm=5, LDUR rd=0 rn=1 imm=-8 back-to-back with mem_ready=1 -> words 0x17FFFFFF, 0x5400004B, 0x9B057C83, 0xF85F8020 at consecutive addresses +4, no bubbles.
- Hold mem_ready=0 for 3 cycles mid-stream -> mem_we/addr/data stable, in_ready=0, no word lost or duplicated.
- ADDI imm=4096 -> err=1, err_code=2, no write; next start clears err and loads normally.
- DEPTH=4, 5 requests -> 4 writes, then err_code=3; opcode 13 gives err_code=1.
- reset asserted while mem_we=1 -> next cycle all outputs 0 and state IDLE; with ILOAD_CHECKSUM_EN, csum equals the XOR of all written words.
